psum_sram_reader: RTL and testbench

//  Drains accumulated partial sums from the 128b x 2048 psum SRAM and streams them out row by row over valid/ready.
//  It is the read-out counterpart of the core's psum write path: the corelet writes psum rows, this block reads them back.
//  It sits beside the core and shares the psum SRAM read port; psum SRAM CEN/REN is granted to this block only while busy=1.
//  It hides the 1-cycle SRAM read latency behind a 2-entry buffer, so throughput is 1 row/cycle under no backpressure.

---
 rtl/psum_pkg.sv | 19 +
 rtl/psum_skid_fifo.sv | 34 +++
 rtl/psum_sram_reader.sv | 82 ++++++++
 tb/tb_psum_sram_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, FSM states, buffer entry type and the ReLU lane helper for the psum read-out path
package psum_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL = 8;
  localparam int ROW_W = COL * PSUM_BW;
  localparam int SRAM_NUM = 2048;
  localparam int ADDR_W = $clog2(SRAM_NUM);
  localparam int CNT_W = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef struct packed {
    logic last;
    logic [ROW_W-1:0] data;
  } entry_t;
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row, input logic en);
    relu_row = row;
    for (int i = 0; i < COL; i++)
      if (en && row[i*PSUM_BW+PSUM_BW-1]) relu_row[i*PSUM_BW +: PSUM_BW] = '0;
  endfunction
endpackage

// File: rtl/psum_skid_fifo.sv
// psum_skid_fifo: 2-entry FIFO of {last, data}; push and pop may occur in the same cycle
module psum_skid_fifo
  import psum_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output entry_t     dout,
  output logic [1:0] occ,
  output logic       full,
  output logic       empty
);
  entry_t mem [2];
  logic wp, rp;
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem[rp];
  assign full = occ == 2'd2;
  assign empty = occ == 2'd0;
endmodule

// File: rtl/psum_sram_reader.sv
// psum_sram_reader: streams psum SRAM rows out over valid/ready, hiding the 1-cycle read latency with a 2-entry buffer
module psum_sram_reader
  import psum_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_ra,
  input  logic [ROW_W-1:0]  sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic              out_last
);
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt, issued;
  logic relu_q, inflight, inflight_last, pop, credit, last_issue, full, empty;
  logic [1:0] occ;
  entry_t din, head;
  assign pop = out_valid & out_ready;
  // a read may issue only if buffer + in-flight, after this cycle's pop, leaves a free slot
  assign credit = inflight ? (occ == 2'd0 || (occ == 2'd1 && pop)) : (!full || pop);
  assign last_issue = issued == cnt - CNT_W'(1);
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? (count == '0 ? DONE : RUN) : IDLE) :
              state == RUN   ? (sram_ren && last_issue ? FLUSH : RUN) :
              state == FLUSH ? (empty && !inflight ? DONE : FLUSH) : IDLE;
  end
  always_comb begin
    busy = state == RUN || state == FLUSH;
    done = state == DONE;
    sram_ren = state == RUN && credit;
    sram_cen = !sram_ren;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      issued <= '0;
      relu_q <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ptr <= base_addr;
        cnt <= count > CNT_W'(SRAM_NUM) ? CNT_W'(SRAM_NUM) : count;
        relu_q <= relu_en;
        issued <= '0;
      end else if (sram_ren) begin
        ptr <= ptr == ADDR_W'(SRAM_NUM - 1) ? '0 : ptr + 1'b1;
        issued <= issued + 1'b1;
      end
      inflight <= sram_ren;
      inflight_last <= sram_ren && last_issue;
    end
  end
  assign sram_ra = ptr;
  assign din = '{last: inflight_last, data: relu_row(sram_q, relu_q)};
  psum_skid_fifo u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (inflight),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .occ  (occ),
    .full (full),
    .empty(empty)
  );
  assign out_valid = !empty;
  assign out_data = head.data;
  assign out_last = head.last;
endmodule

// File: tb/tb_psum_sram_reader.sv
// tb_psum_sram_reader: randomized scoreboard bench with an SRAM model and a row-level reference model
module tb_psum_sram_reader;
  import psum_pkg::*;
  typedef struct {
    logic last;
    logic [ROW_W-1:0] data;
  } exp_t;
  logic clk = 0, reset = 1, start = 0, relu_en = 0, out_ready = 1;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic busy, done, sram_cen, sram_ren, out_valid, out_last;
  logic [ADDR_W-1:0] sram_ra;
  logic [ROW_W-1:0] sram_q = '0, out_data;
  logic [ROW_W-1:0] mem [SRAM_NUM];
  exp_t exp_q[$];
  int addr_q[$];
  int n_chk = 0, n_fail = 0, dones_exp = 0, dones_seen = 0, rdy_mode = 0;
  bit fin = 0, expect_idle = 0;

  always #5 clk = ~clk;

  psum_sram_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .relu_en(relu_en), .busy(busy), .done(done), .sram_cen(sram_cen), .sram_ren(sram_ren),
    .sram_ra(sram_ra), .sram_q(sram_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always @(posedge clk) if (!sram_cen && sram_ren) sram_q <= mem[sram_ra];

  // row as the consumer should see it: negative lanes zeroed when relu is on
  function automatic logic [ROW_W-1:0] model_row(input int a, input bit r);
    logic [ROW_W-1:0] v;
    v = mem[a];
    if (r)
      for (int i = 0; i < COL; i++)
        if ($signed(v[i*PSUM_BW +: PSUM_BW]) < 0) v[i*PSUM_BW +: PSUM_BW] = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic issue(input int b, input int c, input bit r);
    int n;
    exp_t e;
    n = c > SRAM_NUM ? SRAM_NUM : c;
    for (int k = 0; k < n; k++) begin
      e.last = k == n - 1;
      e.data = model_row((b + k) % SRAM_NUM, r);
      exp_q.push_back(e);
      addr_q.push_back((b + k) % SRAM_NUM);
    end
    base_addr = ADDR_W'(b);
    count = CNT_W'(c);
    relu_en = r;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (!done && t < lim) begin
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", lim);
      $fatal(1);
    end
    dones_exp++;
    @(posedge clk); #1;
  endtask

  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1;
        1: begin out_ready = pat[ph]; ph = (ph + 1) % 4; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  initial begin
    int t;
    for (int i = 0; i < SRAM_NUM; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) mem[i][PSUM_BW-1:0] = PSUM_BW'(i);
    mem[100] = {16'h8001, 16'h1234, 16'h7fff, 16'hffff, 16'h0001, 16'h8000, 16'h0007, 16'hfffb};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    expect_idle = 1;
    @(posedge clk); #1;
    expect_idle = 0;
    rdy_mode = 0; issue(0, 8, 0); wait_done(100);
    rdy_mode = 1; issue(0, 8, 0); wait_done(200);
    rdy_mode = 0; issue(2046, 4, 0); wait_done(100);
    issue(100, 1, 1); wait_done(50);
    issue(100, 1, 0); wait_done(50);
    issue(0, 0, 0); wait_done(20);
    issue(10, 6, 0);
    @(posedge clk); #1;
    base_addr = ADDR_W'(500); count = CNT_W'(3); start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(100);
    for (int j = 0; j < 12; j++) begin
      rdy_mode = 2;
      issue(int'($urandom_range(0, SRAM_NUM - 1)), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
      wait_done(400);
    end
    rdy_mode = 0; issue(1000, 4000, 1); wait_done(3000);
    rdy_mode = 3; issue(20, 8, 0);
    t = 0;
    while (!out_valid && t < 10) begin @(posedge clk); #1; t++; end
    if (!out_valid) begin
      $display("FAIL valid_timeout: out_valid=0 after 10 cycles, expected 1");
      $fatal(1);
    end
    reset = 1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    reset = 0;
    expect_idle = 1;
    @(posedge clk); #1;
    expect_idle = 0;
    rdy_mode = 2; issue(300, 5, 1); wait_done(100);
    fin = 1;
  end

  initial begin
    int iss, popd;
    bit pv, pr, pdn, pop_now;
    logic [ROW_W-1:0] pdat;
    exp_t e;
    iss = 0; popd = 0; pv = 0; pr = 0; pdn = 0; pdat = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        iss = 0; popd = 0; pv = 0; pdn = 0;
      end else begin
        if (expect_idle) begin
          chk("idle_busy", ROW_W'(busy), '0);
          chk("idle_done", ROW_W'(done), '0);
          chk("idle_cen", ROW_W'(sram_cen), ROW_W'(1));
          chk("idle_ren", ROW_W'(sram_ren), '0);
          chk("idle_ra", ROW_W'(sram_ra), '0);
          chk("idle_valid", ROW_W'(out_valid), '0);
          chk("idle_last", ROW_W'(out_last), '0);
          chk("idle_data", out_data, '0);
        end
        chk("cen_vs_ren", ROW_W'(sram_cen), ROW_W'(!sram_ren));
        pop_now = out_valid && out_ready;
        if (sram_ren) begin
          chk("ren_busy", ROW_W'(busy), ROW_W'(1));
          chk("credit", ROW_W'(iss - popd - int'(pop_now) < 2), ROW_W'(1));
          chk("read_expected", ROW_W'(addr_q.size() > 0), ROW_W'(1));
          if (addr_q.size() > 0) chk("sram_ra", ROW_W'(sram_ra), ROW_W'(addr_q.pop_front()));
          iss++;
        end
        if (pv && !pr) begin
          chk("stall_valid", ROW_W'(out_valid), ROW_W'(1));
          chk("stall_data", out_data, pdat);
        end
        if (pop_now) begin
          chk("row_expected", ROW_W'(exp_q.size() > 0), ROW_W'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", ROW_W'(out_last), ROW_W'(e.last));
          end
          popd++;
        end
        if (done) begin
          chk("done_width", ROW_W'(pdn), '0);
          chk("done_rows_left", ROW_W'(exp_q.size()), '0);
          chk("done_reads_left", ROW_W'(addr_q.size()), '0);
          chk("done_busy", ROW_W'(busy), '0);
          dones_seen++;
        end
        pv = out_valid; pr = out_ready; pdat = out_data; pdn = done;
        if (fin) begin
          chk("done_count", ROW_W'(dones_seen), ROW_W'(dones_exp));
          $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1);
  end
endmodule
